// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy game control path.
//   state_e   : game FSM state encoding (IDLE=0, PLAY=1, DEAD=2)
//   COORD_W   : width of every screen coordinate
//   SCORE_MAX : saturating BCD score ceiling
//   bcd_inc   : two-digit BCD increment that saturates at SCORE_MAX
package flappy_pkg;

    localparam int unsigned COORD_W   = 12;
    localparam int unsigned SCORE_W   = 8;
    localparam logic [7:0]  SCORE_MAX = 8'h99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_e;

    // Units roll 9 -> 0 with a carry into tens; 99 stays at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s == SCORE_MAX) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/flap_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_btn        : raw asynchronous button
//   o_stable     : debounced button level
//   o_press      : one-cycle pulse, registered one cycle after o_stable rises
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_stable,
    output logic o_press
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync_q1;
    logic             sync_q2;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Level only moves after DB_CYCLES consecutive cycles of disagreement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q1  <= 1'b0;
            sync_q2  <= 1'b0;
            o_stable <= 1'b0;
            stable_d <= 1'b0;
            o_press  <= 1'b0;
            cnt      <= '0;
        end else begin
            sync_q1  <= i_btn;
            sync_q2  <= sync_q1;
            stable_d <= o_stable;
            o_press  <= o_stable & ~stable_d;
            if (sync_q2 != o_stable) begin
                if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                    o_stable <= sync_q2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/flap_ctrl.sv
// Game control: debounced flap pulses, IDLE/PLAY/DEAD FSM, pipe collision
// detection and a saturating 2-digit BCD score.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_ani_stb             : one-cycle frame strobe
//   i_btn                 : raw player button
//   i_bird_x1..i_bird_y2  : bird bounding box
//   i_out_of_bounds       : bird left the playfield
//   i_pipe_x1, i_pipe_x2  : pipe left/right edges
//   i_gap_y1, i_gap_y2    : open gap top/bottom edges
//   o_flap                : one-cycle flap pulse to the bird block
//   o_bird_rst            : holds the bird at its start position (IDLE)
//   o_animate             : bird physics enable (PLAY)
//   o_score               : BCD score, [7:4] tens, [3:0] units
//   o_state               : current FSM state
module flap_ctrl
    import flappy_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned DEAD_FRAMES = 60
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ani_stb,
    input  logic               i_btn,
    input  logic [COORD_W-1:0] i_bird_x1,
    input  logic [COORD_W-1:0] i_bird_x2,
    input  logic [COORD_W-1:0] i_bird_y1,
    input  logic [COORD_W-1:0] i_bird_y2,
    input  logic               i_out_of_bounds,
    input  logic [COORD_W-1:0] i_pipe_x1,
    input  logic [COORD_W-1:0] i_pipe_x2,
    input  logic [COORD_W-1:0] i_gap_y1,
    input  logic [COORD_W-1:0] i_gap_y2,
    output logic               o_flap,
    output logic               o_bird_rst,
    output logic               o_animate,
    output logic [7:0]         o_score,
    output logic [1:0]         o_state
);

    localparam int unsigned DC_W = $clog2(DEAD_FRAMES + 1);

    state_e            state_q, state_d;
    logic [DC_W-1:0]   dead_q, dead_d;
    logic [7:0]        score_d;
    logic              flap_d, bird_rst_d, animate_d;
    logic              prev_passed;
    logic              btn_stable, btn_pulse, press;
    logic              overlap_c, breach_c, hit_c, passed_c, score_evt_c;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_btn    (i_btn),
        .o_stable (btn_stable),
        .o_press  (btn_pulse)
    );

    // A press only counts while the debounced level is still held.
    assign press = btn_pulse & btn_stable;

    // Collision: box overlaps the pipe column and pokes outside the gap.
    assign overlap_c   = (i_bird_x2 >= i_pipe_x1) && (i_bird_x1 <= i_pipe_x2);
    assign breach_c    = (i_bird_y1 < i_gap_y1) || (i_bird_y2 > i_gap_y2);
    assign hit_c       = i_out_of_bounds | (overlap_c & breach_c);
    assign passed_c    = i_pipe_x2 < i_bird_x1;
    assign score_evt_c = passed_c & ~prev_passed;

    assign o_state = state_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        score_d = o_score;
        flap_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = PLAY;
                    score_d = '0;
                    flap_d  = 1'b1;
                end
            end
            PLAY: begin
                if (hit_c) begin
                    state_d = DEAD;
                    dead_d  = '0;
                end else begin
                    flap_d = press;
                    if (score_evt_c) begin
                        score_d = bcd_inc(o_score);
                    end
                end
            end
            DEAD: begin
                // Exit decision uses the count from before this cycle's strobe.
                if (i_ani_stb && (dead_q != DC_W'(DEAD_FRAMES))) begin
                    dead_d = dead_q + DC_W'(1);
                end
                if (press && (dead_q == DC_W'(DEAD_FRAMES))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        bird_rst_d = (state_d == IDLE);
        animate_d  = (state_d == PLAY);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            dead_q      <= '0;
            o_score     <= 8'h00;
            o_flap      <= 1'b0;
            o_bird_rst  <= 1'b1;
            o_animate   <= 1'b0;
            prev_passed <= 1'b0;
        end else begin
            state_q     <= state_d;
            dead_q      <= dead_d;
            o_score     <= score_d;
            o_flap      <= flap_d;
            o_bird_rst  <= bird_rst_d;
            o_animate   <= animate_d;
            prev_passed <= passed_c;
        end
    end

endmodule

// File: tb/tb_flap_ctrl.sv
// Scoreboard bench for flap_ctrl: stimulus queues expected output snapshots,
// a monitor compares every change of the output bundle against the queue.
module tb_flap_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ani = 1'b0;
    logic        btn = 1'b0;
    logic        oob = 1'b0;
    logic [11:0] bx1 = 12'd240, bx2 = 12'd400, by1 = 12'd150, by2 = 12'd200;
    logic [11:0] px1 = 12'd600, px2 = 12'd700, gy1 = 12'd100, gy2 = 12'd300;

    logic        o_flap, o_bird_rst, o_animate;
    logic [7:0]  o_score;
    logic [1:0]  o_state;

    flap_ctrl #(
        .DB_CYCLES   (4),
        .DEAD_FRAMES (3)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ani_stb       (ani),
        .i_btn           (btn),
        .i_bird_x1       (bx1),
        .i_bird_x2       (bx2),
        .i_bird_y1       (by1),
        .i_bird_y2       (by2),
        .i_out_of_bounds (oob),
        .i_pipe_x1       (px1),
        .i_pipe_x2       (px2),
        .i_gap_y1        (gy1),
        .i_gap_y2        (gy2),
        .o_flap          (o_flap),
        .o_bird_rst      (o_bird_rst),
        .o_animate       (o_animate),
        .o_score         (o_score),
        .o_state         (o_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [12:0] snap;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [12:0] prev_snap = '1;

    // snapshot layout: {state[1:0], flap, bird_rst, animate, score[7:0]}
    function automatic logic [12:0] mk(input logic [1:0] st, input logic fl,
                                       input logic br, input logic an,
                                       input logic [7:0] sc);
        return {st, fl, br, an, sc};
    endfunction

    function automatic logic [7:0] bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return 8'(((m / 10) << 4) | (m % 10));
    endfunction

    task automatic expect_ev(input string n, input logic [12:0] s, input int at);
        exp_t e;
        e.name = n;
        e.snap = s;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Monitor: any change of the output bundle is an event to be matched.
    always @(negedge clk) begin : monitor
        logic [12:0] s;
        exp_t        e;
        if (mon_en) begin
            s = {o_state, o_flap, o_bird_rst, o_animate, o_score};
            if (s !== prev_snap) begin
                prev_snap = s;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got snap=%h (state=%0d flap=%0b rst=%0b anim=%0b score=%h) cyc=%0d, required no change",
                             s, s[12:11], s[10], s[9], s[8], s[7:0], cyc);
                end else begin
                    e = exp_q.pop_front();
                    if ((s !== e.snap) || ((e.at >= 0) && (e.at != cyc))) begin
                        errors++;
                        $display("FAIL %s: got snap=%h at cyc=%0d, required snap=%h at cyc=%0d",
                                 e.name, s, cyc, e.snap, e.at);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_btn();
        btn = 1'b0;
        tick(10);
    endtask

    // Raise the button; returns in the cycle whose closing edge consumes the press.
    task automatic btn_rise(output int t0);
        btn = 1'b1;
        t0  = cyc;
        tick(7);
    endtask

    task automatic press_expect(input string n, input logic [12:0] s);
        int t0;
        btn_rise(t0);
        expect_ev(n, s, t0 + 8);
        tick(5);
        release_btn();
    endtask

    task automatic new_game(input string n);
        int t0;
        btn_rise(t0);
        expect_ev({n, "_flap"}, mk(2'd1, 1'b1, 1'b0, 1'b1, 8'h00), t0 + 8);
        expect_ev({n, "_flap_end"}, mk(2'd1, 1'b0, 1'b0, 1'b1, 8'h00), t0 + 9);
        tick(5);
        release_btn();
    endtask

    task automatic pass_pipe();
        px1 = 12'd260; px2 = 12'd320;
        tick(2);
        px1 = 12'd40;  px2 = 12'd100;
        tick(2);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            ani = 1'b1; tick(1);
            ani = 1'b0; tick(1);
        end
    endtask

    initial begin : stim
        int t0;

        // Reset state
        expect_ev("reset", mk(2'd0, 1'b0, 1'b1, 1'b0, 8'h00), -1);
        tick(3);
        rst = 1'b0;
        mon_en = 1'b1;
        tick(2);

        // 1: glitches give nothing, clean press flaps 8 cycles after the rise
        btn = 1'b1; tick(1); btn = 1'b0; tick(6);
        btn = 1'b1; tick(2); btn = 1'b0; tick(8);
        new_game("t1");

        // 2: scoring up through BCD carry to saturation at 99
        for (int n = 1; n <= 99; n++) begin
            expect_ev("t2_score", mk(2'd1, 1'b0, 1'b0, 1'b1, bcd(n)), -1);
            pass_pipe();
        end
        pass_pipe();
        px1 = 12'd600; px2 = 12'd700;
        tick(3);

        // 3: top edge breaches the gap inside the pipe column
        by1 = 12'd40; px1 = 12'd300; px2 = 12'd360;
        expect_ev("t3_hit", mk(2'd2, 1'b0, 1'b0, 1'b0, 8'h99), cyc + 1);
        tick(1);
        by1 = 12'd150; px1 = 12'd600; px2 = 12'd700;
        tick(3);

        // 4: press on the 3rd strobe uses the old count (2) and is ignored
        strobes(2);
        btn_rise(t0);
        ani = 1'b1; tick(1); ani = 1'b0;
        tick(4);
        release_btn();
        press_expect("t4_idle", mk(2'd0, 1'b0, 1'b1, 1'b0, 8'h99));

        // 5a: hit and press together -> DEAD without a flap
        new_game("t5a");
        btn_rise(t0);
        oob = 1'b1;
        expect_ev("t5_hit_press", mk(2'd2, 1'b0, 1'b0, 1'b0, 8'h00), t0 + 8);
        tick(1);
        oob = 1'b0;
        release_btn();
        strobes(5);
        press_expect("t5a_idle", mk(2'd0, 1'b0, 1'b1, 1'b0, 8'h00));

        // 5b: hit and score event together -> no increment
        new_game("t5b");
        px1 = 12'd260; px2 = 12'd320;
        tick(2);
        px1 = 12'd40; px2 = 12'd100; oob = 1'b1;
        expect_ev("t5_hit_score", mk(2'd2, 1'b0, 1'b0, 1'b0, 8'h00), cyc + 1);
        tick(1);
        oob = 1'b0; px1 = 12'd600; px2 = 12'd700;
        tick(2);
        strobes(3);
        press_expect("t5b_idle", mk(2'd0, 1'b0, 1'b1, 1'b0, 8'h00));

        // 6: reset mid-debounce in PLAY with score 07
        new_game("t6");
        for (int n = 1; n <= 7; n++) begin
            expect_ev("t6_score", mk(2'd1, 1'b0, 1'b0, 1'b1, bcd(n)), -1);
            pass_pipe();
        end
        px1 = 12'd600; px2 = 12'd700;
        tick(2);
        btn = 1'b1;
        tick(4);
        rst = 1'b1; btn = 1'b0;
        expect_ev("t6_reset", mk(2'd0, 1'b0, 1'b1, 1'b0, 8'h00), cyc + 1);
        tick(3);
        rst = 1'b0;
        tick(20);
        new_game("t6_fresh");

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unmatched expectations, required 0 (next: %s)",
                     exp_q.size(), exp_q[0].name);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
